data_write_buffer: RTL and testbench

DATA_WRITE_BUFFER -- requirements
Module: data_write_buffer

---
 rtl/data_write_buffer_pkg.sv | 36 +++
 rtl/data_write_buffer_addr_match.sv | 12 +
 rtl/data_write_buffer.sv | 148 ++++++++++++++
 tb/tb_data_write_buffer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_write_buffer_pkg.sv
// Shared types for the data write buffer: drain FSM encoding,
// entry record, line/word type constants and a byte-merge helper.
package data_write_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    localparam logic TYPE_WORD = 1'b0;
    localparam logic TYPE_LINE = 1'b1;

    typedef struct packed {
        logic         typ;
        logic [31:0]  addr;
        logic [2:0]   size;
        logic [3:0]   wstrb;
        logic [127:0] data;
    } entry_t;

    // Overlay the strobed bytes of a new word onto an existing word
    function automatic logic [31:0] merge_word(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input logic [3:0]  be
    );
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/data_write_buffer_addr_match.sv
// Per-entry hazard comparator: 16-byte granule match
// qualified by the entry's valid bit.
module wbuf_addr_match (
    input  logic        valid_i,
    input  logic [27:0] entry_tag_i,
    input  logic [27:0] chk_tag_i,
    output logic        hit_o
);

    assign hit_o = valid_i && (entry_tag_i == chk_tag_i);

endmodule

// File: rtl/data_write_buffer.sv
// Data write buffer: circular FIFO of dcache writes drained one at a
// time to the bridge. Optional word merging under `WBUF_MERGE_EN.
module data_write_buffer
    import data_write_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         wb_req,
    input  logic         wb_type,
    input  logic [31:0]  wb_addr,
    input  logic [2:0]   wb_size,
    input  logic [3:0]   wb_wstrb,
    input  logic [127:0] wb_data,
    output logic         wb_rdy,
    input  logic [31:0]  chk_addr,
    output logic         chk_hit,
    output logic         empty,
    output logic         data_wr_req,
    output logic         data_wr_type,
    output logic [31:0]  data_wr_addr,
    output logic [2:0]   data_wr_size,
    output logic [3:0]   data_wr_wstrb,
    output logic [127:0] data_wr_data,
    input  logic         data_wr_rdy,
    input  logic         data_wr_ok
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    state_e         state_q, state_d;
    logic [PW-1:0]  head_q, head_d;
    logic [PW-1:0]  tail_q, tail_d;
    logic [CW-1:0]  count_q, count_d;
    entry_t         mem_q [DEPTH];

    logic           push, pop, merge, alloc;
    logic [PW-1:0]  newest;
    logic [DEPTH-1:0] valid, hit;
    entry_t         head_e;
    logic           unused_ok;

    assign unused_ok = ^chk_addr[3:0];

    assign wb_rdy = count_q < CW'(DEPTH);
    assign push   = wb_req && wb_rdy;
    assign pop    = (state_q == ST_WAIT) && data_wr_ok;
    assign newest = tail_q - 1'b1;

`ifdef WBUF_MERGE_EN
    assign merge = push
                && (wb_type == TYPE_WORD)
                && (count_q != '0)
                && (mem_q[newest].typ == TYPE_WORD)
                && (mem_q[newest].addr[31:2] == wb_addr[31:2])
                && !((newest == head_q) && (state_q != ST_IDLE));
`else
    assign merge = 1'b0;
`endif

    assign alloc = push && !merge;

    // Pointer and occupancy next-state
    always_comb begin
        head_d  = head_q + PW'(pop);
        tail_d  = tail_q + PW'(alloc);
        count_d = count_q + CW'(alloc) - CW'(pop);
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload storage, intentionally left unreset
    always_ff @(posedge clk) begin
        if (alloc) begin
            mem_q[tail_q] <= '{typ:   wb_type,
                               addr:  wb_addr,
                               size:  wb_size,
                               wstrb: wb_wstrb,
                               data:  wb_data};
        end
        if (merge) begin
            mem_q[newest].data[31:0] <= merge_word(
                mem_q[newest].data[31:0], wb_data[31:0], wb_wstrb);
            mem_q[newest].wstrb <= mem_q[newest].wstrb | wb_wstrb;
            mem_q[newest].addr  <= {wb_addr[31:2], 2'b00};
            mem_q[newest].size  <= 3'd2;
        end
    end

    // Drain FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Drain FSM next-state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (count_q != '0) state_d = ST_REQ;
            ST_REQ:  if (data_wr_rdy)   state_d = ST_WAIT;
            ST_WAIT: if (data_wr_ok)    state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Drain FSM outputs
    always_comb begin
        data_wr_req = (state_q == ST_REQ);
        empty       = (count_q == '0) && (state_q == ST_IDLE);
    end

    assign head_e        = mem_q[head_q];
    assign data_wr_type  = head_e.typ;
    assign data_wr_addr  = head_e.addr;
    assign data_wr_size  = head_e.size;
    assign data_wr_wstrb = head_e.wstrb;
    assign data_wr_data  = head_e.data;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic [PW-1:0] off;
        assign off      = PW'(i) - head_q;
        assign valid[i] = {1'b0, off} < count_q;

        wbuf_addr_match u_match (
            .valid_i     (valid[i]),
            .entry_tag_i (mem_q[i].addr[31:4]),
            .chk_tag_i   (chk_addr[31:4]),
            .hit_o       (hit[i])
        );
    end

    assign chk_hit = |hit;

endmodule

// File: tb/tb_data_write_buffer.sv
// Bench for data_write_buffer: queue-based model checked every cycle
// plus directed scenarios with literal expectations.
module tb_data_write_buffer;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         wb_req = 1'b0;
    logic         wb_type = 1'b0;
    logic [31:0]  wb_addr = '0;
    logic [2:0]   wb_size = '0;
    logic [3:0]   wb_wstrb = '0;
    logic [127:0] wb_data = '0;
    logic         wb_rdy;
    logic [31:0]  chk_addr = '0;
    logic         chk_hit;
    logic         empty;
    logic         data_wr_req;
    logic         data_wr_type;
    logic [31:0]  data_wr_addr;
    logic [2:0]   data_wr_size;
    logic [3:0]   data_wr_wstrb;
    logic [127:0] data_wr_data;
    logic         data_wr_rdy = 1'b0;
    logic         data_wr_ok = 1'b0;

    data_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .wb_req        (wb_req),
        .wb_type       (wb_type),
        .wb_addr       (wb_addr),
        .wb_size       (wb_size),
        .wb_wstrb      (wb_wstrb),
        .wb_data       (wb_data),
        .wb_rdy        (wb_rdy),
        .chk_addr      (chk_addr),
        .chk_hit       (chk_hit),
        .empty         (empty),
        .data_wr_req   (data_wr_req),
        .data_wr_type  (data_wr_type),
        .data_wr_addr  (data_wr_addr),
        .data_wr_size  (data_wr_size),
        .data_wr_wstrb (data_wr_wstrb),
        .data_wr_data  (data_wr_data),
        .data_wr_rdy   (data_wr_rdy),
        .data_wr_ok    (data_wr_ok)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    typedef struct {
        logic         typ;
        logic [31:0]  addr;
        logic [2:0]   size;
        logic [3:0]   wstrb;
        logic [127:0] data;
    } ent_t;

    ent_t q[$];
    int   ms = 0;  // 0 idle, 1 request shown, 2 awaiting completion

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q.delete();
            ms = 0;
        end else begin
            int   sz0;
            int   nms;
            logic do_push;
            logic do_merge;
            ent_t e;
            sz0      = q.size();
            nms      = ms;
            do_push  = wb_req && (sz0 < DEPTH);
            do_merge = 1'b0;
`ifdef WBUF_MERGE_EN
            if (do_push && wb_type == 1'b0 && sz0 > 0)
                if (q[sz0-1].typ == 1'b0 &&
                    q[sz0-1].addr[31:2] == wb_addr[31:2] &&
                    !(sz0 == 1 && ms != 0))
                    do_merge = 1'b1;
`endif
            case (ms)
                0: if (sz0 > 0) nms = 1;
                1: if (data_wr_rdy) nms = 2;
                2: if (data_wr_ok) nms = 0;
                default: nms = 0;
            endcase
            if (ms == 2 && data_wr_ok) void'(q.pop_front());
            if (do_merge) begin
                e = q[q.size()-1];
                for (int b = 0; b < 4; b++)
                    if (wb_wstrb[b]) e.data[8*b +: 8] = wb_data[8*b +: 8];
                e.wstrb = e.wstrb | wb_wstrb;
                e.addr  = {wb_addr[31:2], 2'b00};
                e.size  = 3'd2;
                q[q.size()-1] = e;
            end else if (do_push) begin
                e.typ   = wb_type;
                e.addr  = wb_addr;
                e.size  = wb_size;
                e.wstrb = wb_wstrb;
                e.data  = wb_data;
                q.push_back(e);
            end
            ms = nms;
        end
    end

    // Compare DUT against model on the falling edge
    always @(negedge clk) begin
        logic h;
        h = 1'b0;
        foreach (q[i]) if (q[i].addr[31:4] == chk_addr[31:4]) h = 1'b1;
        chk("m_wb_rdy", wb_rdy, q.size() < DEPTH);
        chk("m_empty", empty, q.size() == 0 && ms == 0);
        chk("m_req", data_wr_req, ms == 1);
        chk("m_hit", chk_hit, h);
        if (ms != 0 && q.size() > 0) begin
            chk("m_type", data_wr_type, q[0].typ);
            chk("m_addr", data_wr_addr, q[0].addr);
            chk("m_size", data_wr_size, q[0].size);
            chk("m_wstrb", data_wr_wstrb, q[0].wstrb);
            chk("m_data", data_wr_data, q[0].data);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic t, input logic [31:0] a,
                        input logic [2:0] s, input logic [3:0] w,
                        input logic [127:0] d);
        wb_req   = 1'b1;
        wb_type  = t;
        wb_addr  = a;
        wb_size  = s;
        wb_wstrb = w;
        wb_data  = d;
        step();
        wb_req = 1'b0;
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (!data_wr_req && n < 20) begin
            step();
            n++;
        end
        chk("req_timeout", data_wr_req, 1'b1);
    endtask

    task automatic drain_one(input logic [31:0] exp_addr);
        wait_req();
        chk("drain_addr", data_wr_addr, exp_addr);
        data_wr_rdy = 1'b1;
        step();
        data_wr_rdy = 1'b0;
        data_wr_ok = 1'b1;
        step();
        data_wr_ok = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    initial begin
        step();
        chk("rst_wb_rdy", wb_rdy, 1'b1);
        chk("rst_empty", empty, 1'b1);
        chk("rst_req", data_wr_req, 1'b0);
        chk("rst_hit", chk_hit, 1'b0);
        step();
        resetn = 1'b1;
        step();

        // Single line: wb_req presented in cycle N, captured at edge
        // N+1, request visible after edge N+2
        push(1'b1, 32'h1FC0_0010, 3'd4, 4'hF,
             128'h0123456789ABCDEF0123456789ABCDEF);
        chk("lat_early", data_wr_req, 1'b0);
        step();
        chk("lat_req", data_wr_req, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("hold_addr", data_wr_addr, 32'h1FC0_0010);
            chk("hold_data", data_wr_data,
                128'h0123456789ABCDEF0123456789ABCDEF);
            chk("hold_type", data_wr_type, 1'b1);
            step();
        end
        data_wr_rdy = 1'b1;
        step();
        data_wr_rdy = 1'b0;
        chk("wait_req_low", data_wr_req, 1'b0);
        chk("wait_not_empty", empty, 1'b0);
        data_wr_ok = 1'b1;
        step();
        data_wr_ok = 1'b0;
        chk("single_empty", empty, 1'b1);

        // Fill to capacity; the fifth request must be dropped
        for (int i = 0; i < 4; i++)
            push(1'b1, 32'h2000_0000 + 32'(i * 16), 3'd4, 4'hF,
                 128'(i + 1));
        chk("full_rdy", wb_rdy, 1'b0);
        push(1'b1, 32'h2000_0040, 3'd4, 4'hF, 128'h55);
        chk("full_rdy2", wb_rdy, 1'b0);
        drain_one(32'h2000_0000);
        drain_one(32'h2000_0010);
        drain_one(32'h2000_0020);
        drain_one(32'h2000_0030);
        step();
        chk("fill_empty", empty, 1'b1);

        // Hazard check
        push(1'b1, 32'h8000_0040, 3'd4, 4'hF, 128'hA);
        push(1'b1, 32'h8000_0100, 3'd4, 4'hF, 128'hB);
        chk_addr = 32'h8000_004C;
        #1;
        chk("hit_same_line", chk_hit, 1'b1);
        chk_addr = 32'h8000_0050;
        #1;
        chk("hit_next_line", chk_hit, 1'b0);
        chk_addr = 32'h8000_004C;
        wait_req();
        data_wr_rdy = 1'b1;
        step();
        data_wr_rdy = 1'b0;
        chk("hit_in_wait", chk_hit, 1'b1);
        chk("wait_addr", data_wr_addr, 32'h8000_0040);
        data_wr_ok = 1'b1;
        step();
        data_wr_ok = 1'b0;
        chk("hit_after_pop", chk_hit, 1'b0);
        drain_one(32'h8000_0100);
        chk_addr = 32'h0;

        // Simultaneous push and pop
        push(1'b1, 32'h4000_0000, 3'd4, 4'hF, 128'h1);
        push(1'b1, 32'h4000_0010, 3'd4, 4'hF, 128'h2);
        wait_req();
        data_wr_rdy = 1'b1;
        step();
        data_wr_rdy = 1'b0;
        chk("sim_cnt_pre", dut.count_q, 3'd2);
        data_wr_ok = 1'b1;
        push(1'b1, 32'h4000_0020, 3'd4, 4'hF, 128'h3);
        data_wr_ok = 1'b0;
        chk("sim_cnt", dut.count_q, 3'd2);
        drain_one(32'h4000_0010);
        drain_one(32'h4000_0020);

        // Word merge behind an in-flight head
        push(1'b0, 32'h3000_0000, 3'd2, 4'hF, 128'h11223344);
        wait_req();
        push(1'b0, 32'h1000_0001, 3'd0, 4'b0010, 128'h0000AA00);
        push(1'b0, 32'h1000_0003, 3'd0, 4'b1000, 128'hBB000000);
`ifdef WBUF_MERGE_EN
        chk("merge_cnt", dut.count_q, 3'd2);
        drain_one(32'h3000_0000);
        wait_req();
        chk("merge_addr", data_wr_addr, 32'h1000_0000);
        chk("merge_wstrb", data_wr_wstrb, 4'b1010);
        chk("merge_size", data_wr_size, 3'd2);
        chk("merge_data", data_wr_data[31:0], 32'hBB00AA00);
        drain_one(32'h1000_0000);
`else
        chk("nomerge_cnt", dut.count_q, 3'd3);
        drain_one(32'h3000_0000);
        wait_req();
        chk("nomerge_wstrb", data_wr_wstrb, 4'b0010);
        drain_one(32'h1000_0001);
        drain_one(32'h1000_0003);
`endif
        step();
        chk("merge_empty", empty, 1'b1);

        // Reset while awaiting completion
        push(1'b1, 32'h5000_0000, 3'd4, 4'hF, 128'h9);
        wait_req();
        data_wr_rdy = 1'b1;
        step();
        data_wr_rdy = 1'b0;
        chk_addr = 32'h5000_0004;
        #1;
        chk("pre_rst_hit", chk_hit, 1'b1);
        resetn = 1'b0;
        #1;
        chk("arst_wb_rdy", wb_rdy, 1'b1);
        chk("arst_req", data_wr_req, 1'b0);
        chk("arst_empty", empty, 1'b1);
        chk("arst_hit", chk_hit, 1'b0);
        step();
        resetn = 1'b1;
        data_wr_ok = 1'b1;
        step();
        data_wr_ok = 1'b0;
        chk("stale_ok_cnt", dut.count_q, 3'd0);
        chk("stale_ok_empty", empty, 1'b1);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
